gate_sweep_checker: RTL and testbench

// Self-checking stimulus stage for the basic-gate library. Drives exhaustive input

---
 rtl/gate_sweep_checker.sv | 143 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus/compare stage for a single basic gate: sweeps every input vector,
// holds each for SETTLE+1 cycles, checks dut_y_i against the selected golden function.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       gate_sel_i,
    output logic [N_IN-1:0]  stim_o,
    input  logic             dut_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             first_err_valid_o,
    output logic [N_IN-1:0]  first_err_vec_o
);

    localparam int HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [2:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              fevv_q, fevv_d;
    logic [N_IN-1:0]   fev_q, fev_d;
    logic              pass_q, pass_d;
    logic              expected;
    logic              mismatch;

    always_comb begin
        expected = 1'b0;
        case (sel_q)
            3'd0:    expected = ~stim_q[0];
            3'd1:    expected = &stim_q;
            3'd2:    expected = |stim_q;
            3'd3:    expected = ~&stim_q;
            3'd4:    expected = ~|stim_q;
            3'd5:    expected = ^stim_q;
            3'd6:    expected = ~^stim_q;
            default: expected = stim_q[0];
        endcase
    end

    // Case inequality so an X/Z gate output is flagged in simulation.
    assign mismatch = (dut_y_i !== expected);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stim_d  = stim_q;
        sel_d   = sel_q;
        err_d   = err_q;
        fevv_d  = fevv_q;
        fev_d   = fev_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_APPLY;
                    sel_d   = gate_sel_i;
                    stim_d  = '0;
                    hold_d  = '0;
                    err_d   = '0;
                    fevv_d  = 1'b0;
                    fev_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (hold_q == HOLD_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!fevv_q) begin
                        fevv_d = 1'b1;
                        fev_d  = stim_q;
                    end
                end
                if (stim_q != {N_IN{1'b1}}) begin
                    stim_d  = stim_q + N_IN'(1);
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            stim_q  <= '0;
            sel_q   <= '0;
            err_q   <= '0;
            fevv_q  <= 1'b0;
            fev_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stim_q  <= stim_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            fevv_q  <= fevv_d;
            fev_q   <= fev_d;
            pass_q  <= pass_d;
        end
    end

    assign stim_o            = stim_q;
    assign busy_o            = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done_o            = (state_q == ST_DONE);
    assign pass_o            = pass_q;
    assign err_cnt_o         = err_q;
    assign first_err_valid_o = fevv_q;
    assign first_err_vec_o   = fev_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: three checker instances (1-, 2- and 3-input sweeps) driving behavioural gates.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 1: N_IN=1, behavioural inverter.
    logic       start1 = 1'b0;
    logic [2:0] sel1   = 3'd0;
    logic [0:0] stim1, fev1;
    logic       dy1, busy1, done1, pass1, fevv1;
    logic [7:0] err1;
    assign dy1 = ~stim1[0];

    // Instance 2: N_IN=2, mode2 0 = AND gate, 1 = stuck-at-0.
    logic       start2 = 1'b0;
    logic [2:0] sel2   = 3'd0;
    logic       mode2  = 1'b0;
    logic [1:0] stim2, fev2;
    logic       dy2, busy2, done2, pass2, fevv2;
    logic [7:0] err2;
    assign dy2 = mode2 ? 1'b0 : &stim2;

    // Instance 3: N_IN=3, CNT_W=2, behavioural XNOR.
    logic       start3 = 1'b0;
    logic [2:0] sel3   = 3'd0;
    logic [2:0] stim3, fev3;
    logic       dy3, busy3, done3, pass3, fevv3;
    logic [1:0] err3;
    assign dy3 = ~^stim3;

    gate_sweep_checker #(.N_IN(1), .SETTLE(2), .CNT_W(8)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .gate_sel_i(sel1),
        .stim_o(stim1), .dut_y_i(dy1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .err_cnt_o(err1), .first_err_valid_o(fevv1),
        .first_err_vec_o(fev1)
    );

    gate_sweep_checker #(.N_IN(2), .SETTLE(2), .CNT_W(8)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .gate_sel_i(sel2),
        .stim_o(stim2), .dut_y_i(dy2), .busy_o(busy2), .done_o(done2),
        .pass_o(pass2), .err_cnt_o(err2), .first_err_valid_o(fevv2),
        .first_err_vec_o(fev2)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .CNT_W(2)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .gate_sel_i(sel3),
        .stim_o(stim3), .dut_y_i(dy3), .busy_o(busy3), .done_o(done3),
        .pass_o(pass3), .err_cnt_o(err3), .first_err_valid_o(fevv3),
        .first_err_vec_o(fev3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each wait counts edges after the start edge until done is seen; 100 is the bound.
    task automatic wait_done1(output int n);
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin step(); n++; end
    endtask
    task automatic wait_done2(output int n);
        n = 0;
        while (done2 !== 1'b1 && n < 100) begin step(); n++; end
    endtask
    task automatic wait_done3(output int n);
        n = 0;
        while (done3 !== 1'b1 && n < 100) begin step(); n++; end
    endtask

    initial begin
        int n;
        int dseen;

        // Reset values.
        step(); step();
        rst = 1'b0;
        chk("rst_stim2", stim2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_pass2", pass2, 0);
        chk("rst_err2", err2, 0);
        chk("rst_fevv2", fevv2, 0);
        chk("rst_fev2", fev2, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_err3", err3, 0);

        // 1: NOT golden against an inverter, vector timing.
        sel1 = 3'd0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("t1_busy_k", busy1, 1);
        chk("t1_stim_k", stim1, 0);
        step(); step();
        chk("t1_stim_k2", stim1, 0);
        step();
        chk("t1_stim_k3", stim1, 1);
        step(); step();
        chk("t1_stim_k5", stim1, 1);
        chk("t1_nodone_k5", done1, 0);
        step();
        chk("t1_done", done1, 1);
        chk("t1_busy_done", busy1, 0);
        chk("t1_pass", pass1, 1);
        chk("t1_err", err1, 0);
        chk("t1_fevv", fevv1, 0);
        step();
        chk("t1_done_pulse", done1, 0);

        // 2: AND golden against stuck-at-0.
        sel2 = 3'd1; mode2 = 1'b1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_done2(n);
        chk("t2_latency", n, 12);
        chk("t2_err", err2, 1);
        chk("t2_fev", fev2, 3);
        chk("t2_fevv", fevv2, 1);
        chk("t2_pass", pass2, 0);
        step();
        chk("t2_done_pulse", done2, 0);

        // 3: BUF golden against an inverter.
        sel1 = 3'd7; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_done1(n);
        chk("t3_latency", n, 6);
        chk("t3_err", err1, 2);
        chk("t3_fev", fev1, 0);
        chk("t3_fevv", fevv1, 1);
        chk("t3_pass", pass1, 0);

        // 4: reset mid-sweep after a mismatch has been recorded (NOR golden vs AND gate).
        mode2 = 1'b0; sel2 = 3'd4; start2 = 1'b1;
        step();
        start2 = 1'b0;
        step(); step(); step(); step();
        chk("t4_err_pre", err2, 1);
        chk("t4_fevv_pre", fevv2, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_stim", stim2, 0);
        chk("t4_busy", busy2, 0);
        chk("t4_done", done2, 0);
        chk("t4_err", err2, 0);
        chk("t4_fevv", fevv2, 0);
        chk("t4_fev", fev2, 0);
        chk("t4_pass", pass2, 0);
        dseen = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done2 === 1'b1) dseen++;
        end
        chk("t4_no_done", dseen, 0);
        sel2 = 3'd1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_done2(n);
        chk("t4_re_latency", n, 12);
        chk("t4_re_pass", pass2, 1);
        chk("t4_re_err", err2, 0);

        // 5: start re-pulse and gate_sel change while busy, plus start held across DONE.
        step();
        sel2 = 3'd1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        step(); step(); step();
        start2 = 1'b1; sel2 = 3'd2;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 7; i++) step();
        start2 = 1'b1;
        step();
        chk("t5_done", done2, 1);
        chk("t5_pass", pass2, 1);
        chk("t5_err", err2, 0);
        step();
        start2 = 1'b0;
        chk("t5_done_pulse", done2, 0);
        chk("t5_idle", busy2, 0);
        step();
        chk("t5_start_in_done_ignored", busy2, 0);

        // 6: XOR golden vs XNOR gate, 2-bit counter saturates.
        sel3 = 3'd5; start3 = 1'b1;
        step();
        start3 = 1'b0;
        wait_done3(n);
        chk("t6_latency", n, 24);
        chk("t6_err", err3, 3);
        chk("t6_fev", fev3, 0);
        chk("t6_fevv", fevv3, 1);
        chk("t6_pass", pass3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
